// File: rtl/lif_accumulator.sv
// Leaky integrate-and-fire membrane accumulator: scans captured spike bits one channel
// per clock, saturating-adds signed weights, leaks toward REST, and honours spike feedback.
module lif_accumulator #(
    parameter int N_INPUTS       = 4,
    parameter int WIDTH          = 8,
    parameter int LEAK           = 1,
    parameter int REFRACT_CYCLES = 3,
    parameter int REST           = 0
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       start,
    input  logic [N_INPUTS-1:0]        in_spikes,
    input  logic [N_INPUTS*WIDTH-1:0]  weights,
    input  logic                       spike,
    output logic                       busy,
    output logic                       done,
    output logic signed [WIDTH-1:0]    accumulator_output
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int CNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFRACT_CYCLES - 1);
    localparam logic signed [WIDTH-1:0] REST_W  = WIDTH'(REST);
    localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_LEAK    = 2'd2,
        ST_REFRACT = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [N_INPUTS-1:0]       spikes_q, spikes_d;
    logic [N_INPUTS*WIDTH-1:0] weights_q, weights_d;

    // Overflow is detected from the extra sign bit of a WIDTH+1 sum.
    function automatic logic signed [WIDTH-1:0] sat_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            sat_add = sum[WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = sum[WIDTH-1:0];
        end
    endfunction

    function automatic logic signed [WIDTH-1:0] leak_step(
        input logic signed [WIDTH-1:0] a
    );
        int v;
        int r;
        v = int'(a);
        if (v > REST) begin
            r = v - LEAK;
            if (r < REST) begin
                r = REST;
            end else begin
                r = r;
            end
        end else if (v < REST) begin
            r = v + LEAK;
            if (r > REST) begin
                r = REST;
            end else begin
                r = r;
            end
        end else begin
            r = v;
        end
        leak_step = WIDTH'(r);
    endfunction

    // Next-state and next-output computation; spike feedback overrides the FSM.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        spikes_d  = spikes_q;
        weights_d = weights_q;
        if (spike) begin
            acc_d   = REST_W;
            state_d = ST_REFRACT;
            cnt_d   = CNT_LOAD;
            idx_d   = '0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        spikes_d  = in_spikes;
                        weights_d = weights;
                        idx_d     = '0;
                        state_d   = ST_SCAN;
                        busy_d    = 1'b1;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (spikes_q[idx_q]) begin
                        acc_d = sat_add(acc_q, weights_q[idx_q*WIDTH +: WIDTH]);
                    end else begin
                        acc_d = acc_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_LEAK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_LEAK: begin
                    acc_d   = leak_step(acc_q);
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
                ST_REFRACT: begin
                    acc_d = REST_W;
                    // The final refractory edge doubles as the first edge able to accept start.
                    if (cnt_q == '0) begin
                        if (start) begin
                            spikes_d  = in_spikes;
                            weights_d = weights;
                            idx_d     = '0;
                            state_d   = ST_SCAN;
                            busy_d    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = REST_W;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            acc_q     <= REST_W;
            idx_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spikes_q  <= '0;
            weights_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            spikes_q  <= spikes_d;
            weights_q <= weights_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign accumulator_output = acc_q;

endmodule

// File: tb/tb_lif_accumulator.sv
// Directed self-checking bench for lif_accumulator; a second instance with LEAK=0
// shares all inputs so the no-leak boundary can be compared side by side.
module tb_lif_accumulator;

    logic              clk;
    logic              clear;
    logic              start;
    logic [3:0]        in_spikes;
    logic [31:0]       weights;
    logic              spike;
    logic              busy, done;
    logic signed [7:0] acc;
    logic              busy0, done0;
    logic signed [7:0] acc0;

    int n_tests = 0;
    int n_fail  = 0;

    lif_accumulator u_dut (
        .clk(clk), .clear(clear), .start(start), .in_spikes(in_spikes),
        .weights(weights), .spike(spike), .busy(busy), .done(done),
        .accumulator_output(acc)
    );

    lif_accumulator #(.LEAK(0)) u_dut_noleak (
        .clk(clk), .clear(clear), .start(start), .in_spikes(in_spikes),
        .weights(weights), .spike(spike), .busy(busy0), .done(done0),
        .accumulator_output(acc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One active edge, then park on the following falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Start pulse sampled at E0; inputs are scrambled afterwards to prove capture.
    task automatic do_start(input logic [3:0] sp, input logic [7:0] w3, input logic [7:0] w2,
                            input logic [7:0] w1, input logic [7:0] w0);
        in_spikes = sp;
        weights   = {w3, w2, w1, w0};
        start     = 1'b1;
        tick();
        start     = 1'b0;
        in_spikes = ~sp;
        weights   = 32'h5A5A_5A5A;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        clear     = 1'b1;
        start     = 1'b1;
        spike     = 1'b0;
        in_spikes = 4'($urandom);
        weights   = 32'($urandom);
        @(negedge clk);
        tick(2);
        check_eq("reset_acc", int'(acc), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_acc_noleak", int'(acc0), 0);
        clear = 1'b0;
        start = 1'b0;

        // Basic integration
        do_start(4'b0101, 8'd7, 8'd5, 8'd20, 8'd10);
        check_eq("basic_busy_e0", int'(busy), 1);
        tick(); check_eq("basic_e1", int'(acc), 10);
        tick(); check_eq("basic_e2", int'(acc), 10);
        tick(); check_eq("basic_e3", int'(acc), 15);
        tick(); check_eq("basic_e4", int'(acc), 15);
        check_eq("basic_done_e4", int'(done), 0);
        tick(); check_eq("basic_e5_leak", int'(acc), 14);
        check_eq("basic_done_e5", int'(done), 1);
        check_eq("basic_busy_e5", int'(busy), 0);
        check_eq("noleak_e5", int'(acc0), 15);
        tick(); check_eq("basic_done_once", int'(done), 0);

        // Positive saturation: bring acc to 120 first
        do_start(4'b0001, 8'd0, 8'd0, 8'd0, 8'd107);
        tick(5); check_eq("sat_prep", int'(acc), 120);
        do_start(4'b1111, 8'd30, 8'd30, 8'd30, 8'd30);
        tick(); check_eq("sat_pos_e1", int'(acc), 127);
        tick(3); check_eq("sat_pos_e4", int'(acc), 127);
        tick(); check_eq("sat_pos_leak", int'(acc), 126);

        // Negative saturation from 0
        pulse_clear();
        do_start(4'b1111, 8'h9C, 8'h9C, 8'h9C, 8'h9C);
        tick(); check_eq("sat_neg_e1", int'(acc), -100);
        tick(); check_eq("sat_neg_e2", int'(acc), -128);
        tick(2); check_eq("sat_neg_e4", int'(acc), -128);
        tick(); check_eq("sat_neg_leak", int'(acc), -127);

        // Spike mid-scan at E2
        pulse_clear();
        do_start(4'b0101, 8'd7, 8'd5, 8'd20, 8'd10);
        tick(); check_eq("spk_e1", int'(acc), 10);
        spike = 1'b1;
        tick();
        spike = 1'b0;
        check_eq("spk_acc", int'(acc), 0);
        check_eq("spk_busy1", int'(busy), 1);
        check_eq("spk_done1", int'(done), 0);
        start = 1'b1; in_spikes = 4'b1111; weights = {4{8'd50}};
        tick();
        check_eq("spk_busy2", int'(busy), 1);
        check_eq("spk_acc2", int'(acc), 0);
        check_eq("spk_done2", int'(done), 0);
        tick();
        check_eq("spk_busy3", int'(busy), 1);
        check_eq("spk_acc3", int'(acc), 0);
        do_start(4'b0001, 8'd0, 8'd0, 8'd0, 8'd9);
        check_eq("spk_start_accept", int'(busy), 1);
        tick(); check_eq("spk_new_e1", int'(acc), 9);
        tick(3); check_eq("spk_new_e4", int'(acc), 9);
        tick(); check_eq("spk_new_leak", int'(acc), 8);
        check_eq("spk_new_done", int'(done), 1);

        // Clear mid-scan at E2, then fresh scan
        do_start(4'b0101, 8'd7, 8'd5, 8'd20, 8'd10);
        tick(); check_eq("clr_e1", int'(acc), 18);
        pulse_clear();
        check_eq("clr_acc", int'(acc), 0);
        check_eq("clr_busy", int'(busy), 0);
        check_eq("clr_done", int'(done), 0);
        do_start(4'b0001, 8'd0, 8'd0, 8'd0, 8'd3);
        check_eq("clr_restart_busy", int'(busy), 1);
        tick(); check_eq("clr_new_e1", int'(acc), 3);
        tick(3); check_eq("clr_new_done_e4", int'(done), 0);
        tick(); check_eq("clr_new_leak", int'(acc), 2);
        check_eq("clr_new_done", int'(done), 1);

        // Leak boundaries
        pulse_clear();
        do_start(4'b0000, 8'd1, 8'd1, 8'd1, 8'd1);
        tick(4); check_eq("zero_done_e4", int'(done), 0);
        tick(); check_eq("zero_acc", int'(acc), 0);
        check_eq("zero_done", int'(done), 1);
        do_start(4'b0001, 8'd0, 8'd0, 8'd0, 8'hFE);
        tick(5); check_eq("neg_leak_m1", int'(acc), -1);
        check_eq("noleak_m2", int'(acc0), -2);
        do_start(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        tick(5); check_eq("neg_leak_to_rest", int'(acc), 0);
        check_eq("noleak_hold", int'(acc0), -2);

        // Simultaneous start and spike in IDLE
        start = 1'b1; spike = 1'b1; in_spikes = 4'b1111; weights = {4{8'd40}};
        tick();
        start = 1'b0; spike = 1'b0;
        check_eq("ss_busy", int'(busy), 1);
        check_eq("ss_acc", int'(acc), 0);
        tick();
        check_eq("ss_acc2", int'(acc), 0);
        tick();
        check_eq("ss_busy3", int'(busy), 1);
        tick();
        check_eq("ss_idle", int'(busy), 0);
        check_eq("ss_done", int'(done), 0);
        check_eq("ss_acc_end", int'(acc), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
